// File: rtl/mem_dbus_ctrl.sv
// MEM-stage data-bus controller: issues EX/MEM loads/stores as request/addr_ok/data_ok
// transactions and holds the pipeline until they finish. Optional alignment check: DBUS_ADDR_CHECK_EN.
module mem_dbus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic        mem_ren,
  input  logic [3:0]  mem_wen,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic        stall_in,
  input  logic        refresh,
  output logic        data_req,
  output logic        data_wr,
  output logic [1:0]  data_size,
  output logic [31:0] data_addr,
  output logic [3:0]  data_wstrb,
  output logic [31:0] data_wdata,
  input  logic        data_addr_ok,
  input  logic        data_data_ok,
  input  logic [31:0] data_rdata,
  output logic [31:0] mem_rdata,
  output logic        mem_stall,
  output logic        mem_adel,
  output logic        mem_ades
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t state;
  logic   is_store;
  logic   addr_err;
  logic   access;

  assign is_store = (mem_wen != 4'b0000);

`ifdef DBUS_ADDR_CHECK_EN
  assign addr_err = ((mem_size == 2'd1) & mem_addr[0])
                  | ((mem_size == 2'd2) & (mem_addr[1:0] != 2'b00));
  assign mem_adel = mem_valid & mem_ren  & addr_err;
  assign mem_ades = mem_valid & is_store & addr_err;
`else
  assign addr_err = 1'b0;
  assign mem_adel = 1'b0;
  assign mem_ades = 1'b0;
`endif

  assign access = mem_valid & (mem_ren | is_store) & ~refresh & ~addr_err;

  // EX/MEM is frozen while mem_stall is high, so these stay stable for the whole transaction.
  assign data_wr    = is_store;
  assign data_size  = mem_size;
  assign data_addr  = mem_addr;
  assign data_wstrb = mem_wen;
  assign data_wdata = mem_wdata;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    data_req  = 1'b0;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: begin
        data_req  = access;
        mem_stall = access;
      end
      S_REQ: begin
        data_req  = ~refresh;
        mem_stall = 1'b1;
      end
      S_WAIT, S_DRAIN: mem_stall = 1'b1;
      default: ;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      // NOTE: mem_rdata is a single pipeline register, not a memory array, so it is reset to a known 0.
      mem_rdata <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (access) state <= data_addr_ok ? S_WAIT : S_REQ;
        end
        S_REQ: begin
          if (refresh)           state <= S_IDLE;
          else if (data_addr_ok) state <= S_WAIT;
        end
        S_WAIT: begin
          // A flush landing with the response discards the data outright; earlier, it must drain.
          if (data_data_ok) begin
            if (refresh) begin
              state <= S_IDLE;
            end else begin
              state <= S_DONE;
              if (mem_ren) mem_rdata <= data_rdata;
            end
          end else if (refresh) begin
            state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (~stall_in | refresh) state <= S_IDLE;
        end
        S_DRAIN: begin
          if (data_data_ok) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_dbus_ctrl.sv
// Directed self-checking bench for mem_dbus_ctrl; expectations follow DBUS_ADDR_CHECK_EN when defined.
module tb_mem_dbus_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_ren, stall_in, refresh;
  logic [3:0]  mem_wen;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr, mem_wdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata, mem_rdata;
  logic        mem_stall, mem_adel, mem_ades;

  int n_checks = 0;
  int n_fail   = 0;

  mem_dbus_ctrl dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ren(mem_ren),
    .mem_wen(mem_wen), .mem_size(mem_size), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .stall_in(stall_in), .refresh(refresh), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_addr(data_addr), .data_wstrb(data_wstrb),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata), .mem_rdata(mem_rdata), .mem_stall(mem_stall),
    .mem_adel(mem_adel), .mem_ades(mem_ades)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Inputs change 1ns after the edge; outputs are checked 1ns later, far from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    mem_valid = 0; mem_ren = 0; mem_wen = 4'b0; mem_size = 2'd2;
    mem_addr = 32'h0; mem_wdata = 32'h0; stall_in = 0; refresh = 0;
    data_addr_ok = 0; data_data_ok = 0; data_rdata = 32'h0;
  endtask

  task automatic start_load(input logic [31:0] addr, input logic ok);
    mem_valid = 1; mem_ren = 1; mem_wen = 4'b0; mem_size = 2'd2;
    mem_addr = addr; data_addr_ok = ok;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1;
    tick(); tick();
    settle();
    n_checks++;
    if ({data_req, mem_stall, mem_adel, mem_ades} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 0000", {data_req, mem_stall, mem_adel, mem_ades});
    end
    n_checks++;
    if (mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h want 00000000", mem_rdata);
    end
    reset = 0;
    tick();
  endtask

  task automatic test_load_best();
    start_load(32'h0000_1000, 1'b1);
    settle();
    n_checks++;
    if ({data_req, mem_stall, data_wr, data_wstrb} !== 7'b1100000) begin
      n_fail++; $display("FAIL load_issue: got %b want 1100000", {data_req, mem_stall, data_wr, data_wstrb});
    end
    n_checks++;
    if (data_addr !== 32'h0000_1000 || data_size !== 2'd2) begin
      n_fail++; $display("FAIL load_addr: got %h/%0d want 00001000/2", data_addr, data_size);
    end
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hDEAD_BEEF;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++; $display("FAIL load_wait: got %b want 01", {data_req, mem_stall});
    end
    tick();
    data_data_ok = 0;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b00 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL load_done: got %b/%h want 00/deadbeef", {data_req, mem_stall}, mem_rdata);
    end
    tick();
    mem_valid = 0;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++; $display("FAIL load_idle: got %b want 00", {data_req, mem_stall});
    end
  endtask

  task automatic test_store_delay();
    mem_valid = 1; mem_ren = 0; mem_wen = 4'b0011; mem_size = 2'd1;
    mem_addr = 32'h10; mem_wdata = 32'hAAAA_5555; data_addr_ok = 0;
    for (int i = 0; i < 4; i++) begin
      data_addr_ok = (i == 3);
      settle();
      n_checks++;
      if ({data_req, mem_stall, data_wr, data_wstrb} !== 7'b1110011 || data_wdata !== 32'hAAAA_5555) begin
        n_fail++; $display("FAIL store_req[%0d]: got %b/%h want 1110011/aaaa5555", i,
                           {data_req, mem_stall, data_wr, data_wstrb}, data_wdata);
      end
      tick();
    end
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h0BAD_0BAD;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++; $display("FAIL store_wait: got %b want 01", {data_req, mem_stall});
    end
    tick();
    data_data_ok = 0;
    settle();
    n_checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL store_done: got %b/%h want 0/deadbeef", mem_stall, mem_rdata);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_refresh_req();
    start_load(32'h20, 1'b0);
    settle();
    n_checks++;
    if (data_req !== 1'b1) begin
      n_fail++; $display("FAIL rreq_issue: got %b want 1", data_req);
    end
    tick();
    refresh = 1;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++; $display("FAIL rreq_flush: got %b want 01", {data_req, mem_stall});
    end
    tick();
    refresh = 0; mem_valid = 0;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++; $display("FAIL rreq_idle: got %b want 00", {data_req, mem_stall});
    end
    tick();
  endtask

  task automatic test_refresh_wait();
    start_load(32'h30, 1'b1);
    tick();
    data_addr_ok = 0; refresh = 1;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b01) begin
      n_fail++; $display("FAIL rwait_flush: got %b want 01", {data_req, mem_stall});
    end
    tick();
    refresh = 0;
    start_load(32'h34, 1'b1);
    for (int i = 0; i < 2; i++) begin
      data_data_ok = (i == 1); data_rdata = 32'h1234_5678;
      settle();
      n_checks++;
      if ({data_req, mem_stall} !== 2'b01) begin
        n_fail++; $display("FAIL rwait_drain[%0d]: got %b want 01", i, {data_req, mem_stall});
      end
      tick();
    end
    data_data_ok = 0; mem_valid = 0; data_addr_ok = 0;
    settle();
    n_checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL rwait_keep: got %b/%h want 0/deadbeef", mem_stall, mem_rdata);
    end
    tick();
  endtask

  task automatic test_refresh_same_cycle();
    start_load(32'h38, 1'b1);
    tick();
    data_addr_ok = 0; refresh = 1; data_data_ok = 1; data_rdata = 32'h5555_AAAA;
    tick();
    clear_inputs();
    settle();
    n_checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'hDEAD_BEEF) begin
      n_fail++; $display("FAIL same_cycle: got %b/%h want 0/deadbeef", mem_stall, mem_rdata);
    end
    tick();
  endtask

  task automatic test_stall_done();
    start_load(32'h40, 1'b1);
    stall_in = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'hCAFE_F00D;
    tick();
    data_data_ok = 0; data_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      stall_in = (i < 2);
      settle();
      n_checks++;
      if ({data_req, mem_stall} !== 2'b00 || mem_rdata !== 32'hCAFE_F00D) begin
        n_fail++; $display("FAIL stall_done[%0d]: got %b/%h want 00/cafef00d", i,
                           {data_req, mem_stall}, mem_rdata);
      end
      tick();
    end
    mem_valid = 0;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++; $display("FAIL stall_idle: got %b want 00", {data_req, mem_stall});
    end
    tick();
  endtask

  task automatic test_reset_in_wait();
    start_load(32'h50, 1'b1);
    tick();
    data_addr_ok = 0; reset = 1;
    tick();
    reset = 0; mem_valid = 0; data_data_ok = 1; data_rdata = 32'h9999_9999;
    settle();
    n_checks++;
    if ({data_req, mem_stall} !== 2'b00) begin
      n_fail++; $display("FAIL rst_wait: got %b want 00", {data_req, mem_stall});
    end
    tick();
    data_data_ok = 0;
    settle();
    n_checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_late_ok: got %b/%h want 0/00000000", mem_stall, mem_rdata);
    end
    tick();
  endtask

  task automatic test_misaligned();
    start_load(32'h0000_1002, 1'b0);
`ifdef DBUS_ADDR_CHECK_EN
    settle();
    n_checks++;
    if ({mem_adel, mem_ades, data_req, mem_stall} !== 4'b1000) begin
      n_fail++; $display("FAIL misalign_load: got %b want 1000", {mem_adel, mem_ades, data_req, mem_stall});
    end
    mem_ren = 0; mem_wen = 4'b0011; mem_size = 2'd1; mem_addr = 32'h11;
    settle();
    n_checks++;
    if ({mem_adel, mem_ades, data_req, mem_stall} !== 4'b0100) begin
      n_fail++; $display("FAIL misalign_store: got %b want 0100", {mem_adel, mem_ades, data_req, mem_stall});
    end
    tick();
`else
    settle();
    n_checks++;
    if ({mem_adel, mem_ades, data_req, mem_stall} !== 4'b0011 || data_addr !== 32'h0000_1002) begin
      n_fail++; $display("FAIL misalign_load: got %b/%h want 0011/00001002",
                         {mem_adel, mem_ades, data_req, mem_stall}, data_addr);
    end
    data_addr_ok = 1;
    tick();
    data_addr_ok = 0; data_data_ok = 1; data_rdata = 32'h1002_ABCD;
    tick();
    data_data_ok = 0;
    settle();
    n_checks++;
    if (mem_stall !== 1'b0 || mem_rdata !== 32'h1002_ABCD) begin
      n_fail++; $display("FAIL misalign_done: got %b/%h want 0/1002abcd", mem_stall, mem_rdata);
    end
    tick();
`endif
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_load_best();
    test_store_delay();
    test_refresh_req();
    test_refresh_wait();
    test_refresh_same_cycle();
    test_stall_done();
    test_reset_in_wait();
    test_misaligned();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dbus_ctrl.md
# mem_dbus_ctrl

MEM-stage data-bus controller. It sits between the EX/MEM pipeline register and the MEM/WB pipeline register. It turns the load/store request latched in EX/MEM into a request/addr_ok/data_ok transaction on the SRAM-like data bus. It holds the pipeline while the access is in flight, and presents the raw load word to the MEM/WB register as `mem_rdata`.

## Interface
Parameters:
- none

Ports:
- `clk` in 1: pipeline clock.
- `reset` in 1: synchronous, active-high reset.
- `mem_valid` in 1: the EX/MEM slot holds a live instruction.
- `mem_ren` in 1: load.
- `mem_wen` in 4: store byte strobes; 0 means no store.
- `mem_size` in 2: 0 = byte, 1 = half, 2 = word.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, already lane-aligned.
- `stall_in` in 1: a downstream stage is stalling the pipeline.
- `refresh` in 1: exception/eret flush of the MEM slot.
- `data_req` out 1: bus request.
- `data_wr` out 1: 1 = write.
- `data_size` out 2: access size, equal to `mem_size`.
- `data_addr` out 32: bus address.
- `data_wstrb` out 4: bus byte strobes.
- `data_wdata` out 32: bus write data.
- `data_addr_ok` in 1: request accepted.
- `data_data_ok` in 1: response / write acknowledge.
- `data_rdata` in 32: read data.
- `mem_rdata` out 32: registered load word for MEM/WB.
- `mem_stall` out 1: MEM is busy; the pipeline must hold.
- `mem_adel` out 1: load address error (only when configured, see Configuration).
- `mem_ades` out 1: store address error (only when configured, see Configuration).

## Operation
- `access` = `mem_valid` & (`mem_ren` | (`mem_wen` != 0)) & !`refresh` & !`addr_err`.
- The address, data, size and strobes are forwarded combinationally from the EX/MEM inputs. They stay stable because EX/MEM holds while `mem_stall` is 1.
- State machine states: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - `data_req` = `access`.
  - If `access` & `data_addr_ok`, go to WAIT.
  - Else if `access`, go to REQ.
- REQ:
  - `data_req` = 1.
  - If `refresh`, go to IDLE (no transaction issued; `data_req` is forced to 0 that cycle).
  - Else if `data_addr_ok`, go to WAIT.
- WAIT:
  - `data_req` = 0.
  - On `data_data_ok`, capture `mem_rdata` <= `data_rdata` (loads only; stores leave `mem_rdata` unchanged).
  - If `refresh` arrives before `data_data_ok`, go to DRAIN.
  - Else, on `data_data_ok`, go to DONE.
  - `refresh` and `data_data_ok` in the same cycle: go to IDLE and discard the data.
- DONE:
  - Result is valid.
  - If !`stall_in` or `refresh`, go to IDLE.
- DRAIN:
  - Wait for `data_data_ok`, discard it, go to IDLE.
  - No new request may be issued while in DRAIN.
- `mem_stall` = 1 in REQ, WAIT and DRAIN, and in IDLE while `access`. It is 0 in DONE and in IDLE without access.
- `data_wr` = (`mem_wen` != 0); `data_wstrb` = `mem_wen` for stores, 0 for loads.
- At most one outstanding transaction at any time.

## Timing
- Reset values: state IDLE, `data_req` 0, `mem_stall` 0, `mem_rdata` 0, `mem_adel`/`mem_ades` 0.
- A reset in any state (including WAIT) returns to IDLE. A late `data_data_ok` in IDLE is ignored.
- Best-case latency, with `addr_ok` in the issue cycle and `data_ok` one cycle later:
  - cycle 0: IDLE, handshake.
  - cycle 1: WAIT, `data_ok`.
  - cycle 2: DONE, `mem_rdata` valid, `mem_stall` 0.
  - MEM/WB captures at the end of cycle 2.
- Zero-wait bus where `data_ok` arrives in the cycle after `addr_ok`: the load completes in 3 cycles of MEM occupancy.
- `stall_in` does not block issue. A bus access already accepted always runs to `data_ok`.
- `refresh` takes priority over issue in every state.

## Configuration
- `DBUS_ADDR_CHECK_EN` defined:
  - `addr_err` = (half & `addr[0]`) | (word & `addr[1:0]` != 0).
  - On a load, `mem_adel` = `mem_valid` & `addr_err`; on a store, `mem_ades` = `mem_valid` & `addr_err`. Both are combinational.
  - A faulting access never raises `data_req`.
- Not defined:
  - `addr_err` = 0, and `mem_adel`/`mem_ades` are tied to 0.
  - Misaligned accesses go to the bus unchanged.

## Test plan
- Word load at 0x0000_1000, `addr_ok` same cycle, `data_ok` next cycle with 0xDEAD_BEEF -> `data_req` 1 for exactly 1 cycle; `mem_stall` 1 for 2 cycles; `mem_rdata` = 0xDEAD_BEEF in DONE.
- Store with `mem_wen`=4'b0011 at 0x10, `addr_ok` delayed 3 cycles -> `data_req` held 4 cycles with `data_wstrb`=0011 and `data_wr`=1; `mem_rdata` unchanged.
- `refresh` in REQ before `addr_ok` -> `data_req` drops that cycle; state IDLE; no transaction on the bus.
- `refresh` in WAIT, `data_ok` 2 cycles later with 0x1234_5678 -> DRAIN, `mem_rdata` keeps its old value, `mem_stall` 1 until `data_ok`.
- Load completes while `stall_in`=1 for 3 cycles -> DONE held 3 cycles, no second `data_req`, `mem_rdata` stable.
- With `DBUS_ADDR_CHECK_EN`: word load at 0x0000_1002 -> `mem_adel`=1, `data_req`=0, `mem_stall`=0. Without the macro -> normal bus load at 0x1002.
